interrupt_dispatch: RTL

CPU-side interrupt sequencer, directly downstream of the `interrupt` register block. It takes the live IF/IE values, holds the master enable IME with the EI one-instruction delay, and wakes the core from HALT. It runs the 5-M-cycle dispatch: two wait cycles, push PC high byte, push PC low byte and resolve the vector, then jump. It clears the serviced IF bit through the same `O_IF`/`O_IF_LOAD` path the register block's owner consumes.

---
 rtl/int_pkg.sv | 30 +++
 rtl/int_prio_enc.sv | 17 +
 rtl/interrupt_dispatch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the CPU interrupt sequencer: source bit map,
// dispatch FSM states and vector constants.
package int_pkg;

  localparam int INT_VBLANK  = 0;
  localparam int INT_LCDSTAT = 1;
  localparam int INT_TIMER   = 2;
  localparam int INT_SERIAL  = 3;
  localparam int INT_JOYPAD  = 4;
  localparam int NUM_INT     = 5;

  // Encoder result meaning "nothing pending"; also marks a cancelled dispatch.
  localparam logic [2:0]  VEC_NONE         = 3'd5;
  localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W1,
    ST_W2,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_JUMP
  } disp_state_e;

  // Vector address for source idx: 8-byte slots above base.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [2:0] idx);
    return base + {10'd0, idx, 3'd0};
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder over the interrupt sources; VEC_NONE when idle.
module int_prio_enc
  import int_pkg::*;
(
  input  logic [NUM_INT-1:0] req,
  output logic [2:0]         idx
);

  // Scan high to low so the lowest set bit is the last write and wins.
  always_comb begin
    idx = VEC_NONE;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_dispatch.sv
// Interrupt sequencer: IME with delayed EI, HALT wake, and the 5-M-cycle
// dispatch (wait, wait, push PC hi, push PC lo + IF clear, jump).
module interrupt_dispatch
  import int_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic        I_MCYCLE_EN,
  input  logic [4:0]  I_IF,
  input  logic [4:0]  I_IE,
  input  logic        I_INSTR_BOUNDARY,
  input  logic        I_EI,
  input  logic        I_DI,
  input  logic        I_RETI,
  input  logic        I_HALTED,
  input  logic [15:0] I_PC,
  output logic        O_BUSY,
  output logic        O_PUSH_WE,
  output logic [7:0]  O_PUSH_DATA,
  output logic        O_PC_LOAD,
  output logic [15:0] O_PC,
  output logic [4:0]  O_IF,
  output logic        O_IF_LOAD,
  output logic        O_IME,
  output logic        O_HALT_WAKE
);

  disp_state_e state_q, state_d;
  logic        ime_q, ei_pend_q;
  logic [2:0]  vec_idx_q;
  logic [4:0]  pending;
  logic [2:0]  pend_idx;
  logic        any_pend, take, vec_valid;

  assign pending = I_IF & I_IE;

  int_prio_enc u_prio (
    .req (pending),
    .idx (pend_idx)
  );

  assign any_pend  = (pend_idx != VEC_NONE);
  assign take      = (state_q == ST_IDLE) & I_INSTR_BOUNDARY & ime_q & any_pend & ~I_DI;
  assign vec_valid = (vec_idx_q < VEC_NONE);

  // Wake ignores IME; gated by reset so every output is low while held.
  assign O_HALT_WAKE = I_RESET & I_HALTED & any_pend;
  assign O_IME       = ime_q;

  always_ff @(posedge I_CLOCK or negedge I_RESET) begin
    if (!I_RESET) begin
      state_q   <= ST_IDLE;
      vec_idx_q <= 3'd0;
    end else if (I_MCYCLE_EN) begin
      state_q <= state_d;
      // Latched once; later IF changes cannot retarget the dispatch.
      if (state_q == ST_PUSH_HI) vec_idx_q <= pend_idx;
    end
  end

  // Later assignments override earlier ones: dispatch entry > DI > RETI > EI.
  always_ff @(posedge I_CLOCK or negedge I_RESET) begin
    if (!I_RESET) begin
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
    end else if (I_MCYCLE_EN) begin
      if (ei_pend_q && I_INSTR_BOUNDARY && !I_EI) begin
        ime_q     <= 1'b1;
        ei_pend_q <= 1'b0;
      end
      if (I_EI && !ime_q) ei_pend_q <= 1'b1;
      if (I_RETI) ime_q <= 1'b1;
      if (I_DI || take) begin
        ime_q     <= 1'b0;
        ei_pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    O_BUSY      = 1'b0;
    O_PUSH_WE   = 1'b0;
    O_PUSH_DATA = 8'h00;
    O_PC_LOAD   = 1'b0;
    O_PC        = 16'h0000;
    O_IF        = 5'h00;
    O_IF_LOAD   = 1'b0;
    case (state_q)
      ST_IDLE: if (take) state_d = ST_W1;
      ST_W1: begin
        O_BUSY  = 1'b1;
        state_d = ST_W2;
      end
      ST_W2: begin
        O_BUSY  = 1'b1;
        state_d = ST_PUSH_HI;
      end
      ST_PUSH_HI: begin
        O_BUSY      = 1'b1;
        O_PUSH_WE   = 1'b1;
        O_PUSH_DATA = I_PC[15:8];
        state_d     = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        O_BUSY      = 1'b1;
        O_PUSH_WE   = 1'b1;
        O_PUSH_DATA = I_PC[7:0];
        if (vec_valid) begin
          O_IF_LOAD = 1'b1;
          O_IF      = I_IF & ~(5'd1 << vec_idx_q);
        end
        state_d = ST_JUMP;
      end
      ST_JUMP: begin
        O_BUSY    = 1'b1;
        O_PC_LOAD = 1'b1;
        O_PC      = vec_valid ? vec_addr(VEC_BASE, vec_idx_q) : 16'h0000;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
